// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state enum, counter width and zero-control constant for pipe_stage_reg
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    localparam int KILL_CNT_W = 8;

    // Wide enough for any practical control field; sliced down to CTRL_W at use
    localparam logic [255:0] ZERO_CTRL = '0;

    // Number of valid entries held in a given occupancy state
    function automatic logic [1:0] held_count(input stage_state_t s);
        case (s)
            ONE:     held_count = 2'd1;
            TWO:     held_count = 2'd2;
            default: held_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - width-parametrised counter adding 0..2 per cycle, saturating at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [1:0]   inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W:0]   sum;

    assign sum   = {1'b0, count_q} + {{(W-1){1'b0}}, inc};
    assign count = count_q;

    // Accumulate, clamping to all-ones when the sum carries out
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (sum[W]) begin
            count_q <= '1;
        end else begin
            count_q <= sum[W-1:0];
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with flush and kill counter; PIPE_STAGE_SKID_EN selects a skid buffer
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [CTRL_W-1:0]     in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [KILL_CNT_W-1:0] kill_cnt
);

    stage_state_t      state_q;
    stage_state_t      state_d;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic              in_xfer;
    logic              out_xfer;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // Occupancy state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN

    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic              in_ready_q;

    // Registered ready keeps out_ready off the upstream timing path
    assign in_ready = in_ready_q;

    // Next occupancy: flush empties, otherwise track transfers in and out
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (in_xfer) state_d = ONE;
            ONE: begin
                if (in_xfer && !out_xfer)      state_d = TWO;
                else if (out_xfer && !in_xfer) state_d = EMPTY;
            end
            TWO:     if (out_xfer) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    // Main/skid datapath; bubbles force control bits to zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            in_ready_q <= (state_d != TWO);
            if (flush) begin
                main_ctrl_q <= ZERO_CTRL[CTRL_W-1:0];
                skid_ctrl_q <= ZERO_CTRL[CTRL_W-1:0];
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_xfer) begin
                            main_data_q <= in_data;
                            main_ctrl_q <= in_ctrl;
                        end
                    end
                    ONE: begin
                        if (in_xfer && out_xfer) begin
                            main_data_q <= in_data;
                            main_ctrl_q <= in_ctrl;
                        end else if (in_xfer) begin
                            skid_data_q <= in_data;
                            skid_ctrl_q <= in_ctrl;
                        end else if (out_xfer) begin
                            main_ctrl_q <= ZERO_CTRL[CTRL_W-1:0];
                        end
                    end
                    TWO: begin
                        if (out_xfer) begin
                            main_data_q <= skid_data_q;
                            main_ctrl_q <= skid_ctrl_q;
                            skid_ctrl_q <= ZERO_CTRL[CTRL_W-1:0];
                        end
                    end
                    default: begin
                        main_ctrl_q <= ZERO_CTRL[CTRL_W-1:0];
                        skid_ctrl_q <= ZERO_CTRL[CTRL_W-1:0];
                    end
                endcase
            end
        end
    end

`else

    // Accept whenever the register is empty or is draining this cycle
    assign in_ready = !out_valid || out_ready;

    // Next occupancy: flush wins, a new entry replaces, a drain empties
    always_comb begin
        state_d = state_q;
        if (flush)         state_d = EMPTY;
        else if (in_xfer)  state_d = ONE;
        else if (out_xfer) state_d = EMPTY;
    end

    // Single main register; bubbles force control bits to zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else if (flush) begin
            main_ctrl_q <= ZERO_CTRL[CTRL_W-1:0];
        end else if (in_xfer) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
        end else if (out_xfer) begin
            main_ctrl_q <= ZERO_CTRL[CTRL_W-1:0];
        end
    end

`endif

    sat_counter #(
        .W(KILL_CNT_W)
    ) u_kill_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (flush ? held_count(state_q) : 2'd0),
        .count   (kill_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [15:0]  in_ctrl;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [15:0]  out_ctrl;
    logic [7:0]   kill_cnt;

    int total  = 0;
    int passed = 0;
    int exp_kill = 0;

    pipe_stage_reg dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .kill_cnt  (kill_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 128'h0) $display("FAIL reset_out_data got %h want 0", out_data); else passed++;
        total++; if (out_ctrl !== 16'h0) $display("FAIL reset_out_ctrl got %h want 0", out_ctrl); else passed++;
        total++; if (kill_cnt !== 8'd0) $display("FAIL reset_kill_cnt got %0d want 0", kill_cnt); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_data = 128'hA5; in_ctrl = 16'h0003; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", out_valid); else passed++;
        total++; if (out_data !== 128'hA5) $display("FAIL basic_data got %h want a5", out_data); else passed++;
        total++; if (out_ctrl !== 16'h0003) $display("FAIL basic_ctrl got %h want 0003", out_ctrl); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL basic_drain_valid got %b want 0", out_valid); else passed++;
        total++; if (out_ctrl !== 16'h0) $display("FAIL basic_bubble_ctrl got %h want 0", out_ctrl); else passed++;
        total++; if (out_data !== 128'hA5) $display("FAIL basic_retain_data got %h want a5", out_data); else passed++;
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_data = 128'h11; in_ctrl = 16'h0011; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid !== 1'b1 || out_data !== 128'h11 || out_ctrl !== 16'h0011)
                $display("FAIL stall_hold_%0d got v=%b d=%h c=%h want v=1 d=11 c=0011", i, out_valid, out_data, out_ctrl);
            else passed++;
        end
        in_valid = 1'b1; in_data = 128'h22; in_ctrl = 16'h0022;
`ifdef PIPE_STAGE_SKID_EN
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL stall_skid_ready got %b want 1", in_ready); else passed++;
        tick();
        in_valid = 1'b0;
        total++; if (out_data !== 128'h11) $display("FAIL stall_skid_main got %h want 11", out_data); else passed++;
        out_ready = 1'b1;
        tick();
`else
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL stall_blocked_ready got %b want 0", in_ready); else passed++;
        tick();
        total++; if (out_data !== 128'h11) $display("FAIL stall_no_overwrite got %h want 11", out_data); else passed++;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready got %b want 1", in_ready); else passed++;
        tick();
        in_valid = 1'b0;
`endif
        total++; if (out_valid !== 1'b1 || out_data !== 128'h22 || out_ctrl !== 16'h0022)
            $display("FAIL stall_next got v=%b d=%h c=%h want v=1 d=22 c=0022", out_valid, out_data, out_ctrl);
        else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL stall_no_dup got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 128'(i * 16'h0101); in_ctrl = 16'(i);
            tick();
            total++; if (out_valid !== 1'b1 || out_data !== 128'(i * 16'h0101) || out_ctrl !== 16'(i))
                $display("FAIL b2b_%0d got v=%b d=%h c=%h want v=1 d=%h c=%h", i, out_valid, out_data, out_ctrl, i * 16'h0101, i);
            else passed++;
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data = 128'h33; in_ctrl = 16'h0005; out_ready = 1'b0;
        tick();
        out_ready = 1'b1; in_data = 128'h44; in_ctrl = 16'h0006; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        exp_kill = exp_kill + 1;
        total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", out_valid); else passed++;
        total++; if (out_ctrl !== 16'h0) $display("FAIL flush_ctrl got %h want 0", out_ctrl); else passed++;
        total++; if (kill_cnt !== 8'(exp_kill)) $display("FAIL flush_kill got %0d want %0d", kill_cnt, exp_kill); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL flush_dropped got %b want 0", out_valid); else passed++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (kill_cnt !== 8'(exp_kill)) $display("FAIL flush_empty_kill got %0d want %0d", kill_cnt, exp_kill); else passed++;
    endtask

`ifdef PIPE_STAGE_SKID_EN
    task automatic build_two();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 128'h1; in_ctrl = 16'h0001;
        tick();
        in_data = 128'h2; in_ctrl = 16'h0002;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_skid();
        build_two();
        total++; if (in_ready !== 1'b0) $display("FAIL skid_full_ready got %b want 0", in_ready); else passed++;
        total++; if (out_data !== 128'h1) $display("FAIL skid_full_main got %h want 1", out_data); else passed++;
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 128'h2 || out_ctrl !== 16'h0002)
            $display("FAIL skid_second got v=%b d=%h c=%h want v=1 d=2 c=0002", out_valid, out_data, out_ctrl);
        else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL skid_ready_back got %b want 1", in_ready); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL skid_empty got %b want 0", out_valid); else passed++;
        build_two();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_kill = exp_kill + 2;
        total++; if (kill_cnt !== 8'(exp_kill)) $display("FAIL skid_flush_kill got %0d want %0d", kill_cnt, exp_kill); else passed++;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL skid_flush_state got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        else passed++;
    endtask
`endif

    task automatic test_saturate();
        out_ready = 1'b0;
        while (exp_kill < 254) begin
            in_valid = 1'b1; in_data = 128'h77; in_ctrl = 16'h0001;
            tick();
            in_valid = 1'b0; flush = 1'b1;
            tick();
            flush = 1'b0;
            exp_kill = exp_kill + 1;
        end
        total++; if (kill_cnt !== 8'd254) $display("FAIL sat_preload got %0d want 254", kill_cnt); else passed++;
`ifdef PIPE_STAGE_SKID_EN
        build_two();
`else
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (kill_cnt !== 8'd255) $display("FAIL sat_reach got %0d want 255", kill_cnt); else passed++;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0; flush = 1'b1;
            tick();
            flush = 1'b0;
            total++; if (kill_cnt !== 8'd255) $display("FAIL sat_hold_%0d got %0d want 255", i, kill_cnt); else passed++;
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_data = 128'h55; in_ctrl = 16'h0007; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL areset_pre_valid got %b want 1", out_valid); else passed++;
        #3;
        reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 128'h0 || out_ctrl !== 16'h0 || kill_cnt !== 8'd0)
            $display("FAIL areset_immediate got v=%b d=%h c=%h k=%0d want all zero", out_valid, out_data, out_ctrl, kill_cnt);
        else passed++;
        #4;
        reset_n = 1'b1;
        exp_kill = 0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL areset_ready got %b want 1", in_ready); else passed++;
        tick();
        total++; if (out_valid !== 1'b0 || kill_cnt !== 8'd0 || in_ready !== 1'b1)
            $display("FAIL areset_after got v=%b k=%0d r=%b want v=0 k=0 r=1", out_valid, kill_cnt, in_ready);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_flush();
`ifdef PIPE_STAGE_SKID_EN
        test_skid();
`endif
        test_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
